hamming_seq_ctrl: RTL and testbench
===================================

// Module: hamming_seq_ctrl
// PURPOSE
//  Hardware sequencer for program 1 (Hamming(16,11) encode). On start, walks NUM_MSG
//  11-bit messages in data memory, inserts parity bits p8/p4/p2/p1/p0, and writes
//  the 16-bit codewords back. Sits beside the core as a second data-memory master;
//  an external arbiter grants it the port. Raises done when every codeword is written.
// PARAMETERS
//  NUM_MSG   15  number of messages processed per run (1..127)
//  SRC_BASE  0   byte address of message 0 low byte; message i at SRC_BASE+2i (lo), +2i+1 (hi)
//  DST_BASE  30  byte address of codeword 0 low byte; codeword i at DST_BASE+2i (lo), +2i+1 (hi)
//  ADDR_W    8   data-memory address width
// PORTS
//  clk          in   1       system clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  start        in   1       run request; sampled only in IDLE
//  done         out  1       run complete; held high until next accepted start or reset
//  busy         out  1       high in every state except IDLE/DONE
//  mem_req      out  1       request for data-memory port (high whenever busy)
//  mem_gnt      in   1       arbiter grant; FSM advances only when mem_req & mem_gnt
//  mem_addr     out  ADDR_W  byte address (0 when not busy)
//  mem_wr_en    out  1       write strobe, memory writes on posedge
//  mem_wr_data  out  8       write data (0 when not writing)
//  mem_rd_data  in   8       read data, combinational (asynchronous-read memory)
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, lo/hi latches=0, done=0, busy=0, mem_req=0, mem_wr_en=0.
//  mem_wr_en forced 0 in any cycle where reset is high (no stray write on the reset edge).
//  States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
//   IDLE : start -> RD_LO, idx=0, done=0.
//   RD_LO: addr=SRC_BASE+2*idx; on grant latch lo=mem_rd_data (d[8:1]) -> RD_HI.
//   RD_HI: addr=SRC_BASE+2*idx+1; on grant latch hi=mem_rd_data[2:0] (d[11:9]); bits 7:3 ignored -> WR_LO.
//   WR_LO: addr=DST_BASE+2*idx; wr_en=gnt; data={d4,d3,d2,p4,d1,p2,p1,p0} -> WR_HI.
//   WR_HI: addr=DST_BASE+2*idx+1; wr_en=gnt; data={d11..d5,p8};
//          idx==NUM_MSG-1 -> DONE, else idx++ -> RD_LO.
//   DONE : done=1; start -> RD_LO (new run, idx=0, done drops next cycle); else stay.
//  Grant low: state, idx, latches and address held; mem_wr_en=0; no timeout.
//  Parity: p8=^d[11:5]; p4=^{d11..d8,d4..d2}; p2=^{d11,d10,d7,d6,d4,d3,d1};
//          p1=^{d11,d9,d7,d5,d4,d2,d1}; p0=^d[11:1]^p8^p4^p2^p1 (even overall parity).
//  Latency (gnt tied high): start accepted at edge T; 4 cycles per message; done visible
//   after edge T+4*NUM_MSG (61 cycles for NUM_MSG=15).
//  start while busy: ignored. start held high in DONE: restarts each completion.
//  Reset mid-run: immediate return to IDLE on that edge; partial codewords stay in memory.
//  Address arithmetic ADDR_W bits, wraps modulo 2^ADDR_W (no overflow check).
// STRUCTURE
//  prog1_pkg: state enum typedef, MSG_W=11, CW_W=16 constants, parity-function helpers.
//  Sub-module hamming_enc: combinational d[11:1] -> cw[15:0]; shared with program-2 decoder
//  checker. Controller holds FSM, idx counter, lo/hi latches, address/write muxing.
// TESTING
//  1 d=11'h000 all messages, gnt=1 -> every codeword 16'h0000; done at cycle 61.
//  2 d=11'h7FF -> codeword 16'hFFFF; d=11'h001 -> 16'h000F (lo byte 8'h0F, hi 8'h00).
//  3 15 random messages, hi bytes with junk in bits 7:3 -> match golden encoder, junk ignored.
//  4 gnt toggled pseudo-randomly -> identical memory image, no write while gnt=0.
//  5 reset asserted in WR_LO of message 7 -> no write that edge, IDLE, done=0; restart
//    completes correctly.
//  6 start pulsed while busy -> ignored; start in DONE -> second run, done low one cycle later.

Source files
------------

// File: rtl/prog1_pkg.sv
// Shared types and helpers for the program-1 Hamming(16,11) sequencer.
// Holds the controller state encoding, message/codeword widths and the
// per-parity-bit functions reused by the encoder and the program-2 checker.
package prog1_pkg;

  localparam int MSG_W = 11;
  localparam int CW_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Message bits are numbered d[11:1] to match the codeword position map.
  function automatic logic par_p8(input logic [MSG_W:1] d);
    return ^d[11:5];
  endfunction

  function automatic logic par_p4(input logic [MSG_W:1] d);
    return ^{d[11:8], d[4:2]};
  endfunction

  function automatic logic par_p2(input logic [MSG_W:1] d);
    return ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
  endfunction

  function automatic logic par_p1(input logic [MSG_W:1] d);
    return ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
  endfunction

endpackage

// File: rtl/hamming_enc.sv
// Combinational Hamming(16,11) encoder: d[11:1] -> cw[15:0], SECDED layout.
// Ports: d_i message bits d11..d1; cw_o codeword, cw[0] is overall even parity.
// Zero latency, no state; shared with the program-2 decoder checker.
module hamming_enc
  import prog1_pkg::*;
(
  input  logic [MSG_W:1]  d_i,
  output logic [CW_W-1:0] cw_o
);

  logic p8, p4, p2, p1, p0;

  always_comb begin
    p8 = par_p8(d_i);
    p4 = par_p4(d_i);
    p2 = par_p2(d_i);
    p1 = par_p1(d_i);
    // Overall parity covers every other codeword bit, making the word even.
    p0 = (^d_i) ^ p8 ^ p4 ^ p2 ^ p1;
    cw_o = {d_i[11:5], p8, d_i[4:2], p4, d_i[1], p2, p1, p0};
  end

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Data-memory master that reads NUM_MSG 11-bit messages, Hamming-encodes them
// and writes the 16-bit codewords back. Ports: clk/reset, start/done/busy,
// and a byte-wide req/gnt memory port with asynchronous read data.
module hamming_seq_ctrl
  import prog1_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data
);

  localparam int IDX_W = 7;
  localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(DST_BASE);
  localparam logic [IDX_W-1:0]  LAST_IX = IDX_W'(NUM_MSG - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       lo_q, lo_d;
  logic [2:0]       hi_q, hi_d;

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [CW_W-1:0]   cw;
  logic              wr;
  logic [7:0]        wr_data;

  hamming_enc u_enc (
    .d_i  ({hi_q, lo_q}),
    .cw_o (cw)
  );

  // Addresses wrap modulo 2^ADDR_W by construction.
  assign off      = ADDR_W'({idx_q, 1'b0});
  assign src_addr = SRC_A + off;
  assign dst_addr = DST_A + off;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    mem_addr = '0;
    wr       = 1'b0;
    wr_data  = '0;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_LO;
          idx_d   = '0;
        end
      end
      S_RD_LO: begin
        mem_addr = src_addr;
        if (mem_gnt) begin
          lo_d    = mem_rd_data;
          state_d = S_RD_HI;
        end
      end
      S_RD_HI: begin
        mem_addr = src_addr + ADDR_W'(1);
        if (mem_gnt) begin
          // Only d11..d9 live in the high byte; bits 7:3 are don't-care.
          hi_d    = mem_rd_data[2:0];
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        mem_addr = dst_addr;
        wr       = mem_gnt;
        wr_data  = cw[7:0];
        if (mem_gnt) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr = dst_addr + ADDR_W'(1);
        wr       = mem_gnt;
        wr_data  = cw[15:8];
        if (mem_gnt) begin
          if (idx_q == LAST_IX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_LO;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RD_LO;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req = busy;
    // Reset gates the strobe so the reset edge can never commit a write.
    mem_wr_en   = wr & ~reset;
    mem_wr_data = mem_wr_en ? wr_data : 8'h00;
  end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
module tb_hamming_seq_ctrl;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done, busy, mem_req;
  logic       mem_gnt = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;

  logic [7:0] mem [256];
  assign mem_rd_data = mem[mem_addr];

  hamming_seq_ctrl #(
    .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .ADDR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [15:0] cw;
  } exp_t;
  exp_t exp_q[$];

  logic [10:0] msg [NUM_MSG];
  logic [4:0]  junk [NUM_MSG];
  logic [7:0]  img [2*NUM_MSG];
  logic [7:0]  lo_obs;
  bit          lo_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Golden encoder built from the positional Hamming definition:
  // data fills the non-power-of-two positions, parity k covers positions with bit k set.
  function automatic logic [15:0] golden(input logic [10:0] d);
    logic [15:0] c;
    logic        x;
    int          k;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int j = 1; j < 16; j++)
        if (((j >> b) & 1) == 1 && j != (1 << b)) x ^= c[j];
      c[1 << b] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Memory model and scoreboard: sample away from the active edge.
  always @(negedge clk) begin
    if (reset) check("wr_in_reset", {31'd0, mem_wr_en}, 32'd0);
    if (mem_wr_en) begin
      check("wr_with_gnt", {31'd0, mem_gnt}, 32'd1);
      mem[mem_addr] = mem_wr_data;
      if (((int'(mem_addr) - DST_BASE) % 2) == 0) begin
        lo_obs  = mem_wr_data;
        lo_seen = 1;
      end else if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cw_lo_seen", {31'd0, lo_seen}, 32'd1);
        check("cw_data", {16'd0, mem_wr_data, lo_obs}, {16'd0, e.cw});
        check("cw_addr", {24'd0, mem_addr}, 32'(DST_BASE + 2 * e.idx + 1));
        lo_seen = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    exp_q.delete();
    lo_seen = 0;
    for (int i = 0; i < NUM_MSG; i++) begin
      exp_t e;
      mem[SRC_BASE + 2*i]     = msg[i][7:0];
      mem[SRC_BASE + 2*i + 1] = {junk[i], msg[i][10:8]};
      mem[DST_BASE + 2*i]     = 8'hA5;
      mem[DST_BASE + 2*i + 1] = 8'hA5;
      e.idx = i;
      e.cw  = golden(msg[i]);
      exp_q.push_back(e);
    end
  endtask

  // Starts a run and returns the number of edges, counting the accepting edge,
  // until done is seen. Optionally pulses start once mid-run at edge pulse_at.
  task automatic run(input string tag, input bit rnd, input int pulse_at, output int cyc);
    start = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
      start = (cyc == pulse_at) ? 1'b1 : 1'b0;
      if (cyc == 1) begin
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      end
      if (rnd) mem_gnt = 1'($urandom_range(0, 1));
    end while (!done && cyc < 3000);
    mem_gnt = 1'b1;
    check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    int diff;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) step();
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 1: all-zero messages, gnt tied high, latency
    for (int i = 0; i < NUM_MSG; i++) begin msg[i] = 11'h000; junk[i] = 5'h00; end
    load_mem();
    run("t1", 0, 0, cyc);
    check("t1_latency", 32'(cyc), 32'd61);
    check("t1_busy_done", {31'd0, busy}, 32'd0);
    check("t1_cw0", {16'd0, mem[DST_BASE+1], mem[DST_BASE]}, 32'h0000);

    // 2: all-ones and single-bit message constants
    for (int i = 0; i < NUM_MSG; i++) begin msg[i] = 11'($urandom); junk[i] = 5'($urandom); end
    msg[0] = 11'h7FF;
    msg[1] = 11'h001;
    load_mem();
    run("t2", 0, 0, cyc);
    check("t2_ones_lo", {24'd0, mem[DST_BASE]}, 32'hFF);
    check("t2_ones_hi", {24'd0, mem[DST_BASE+1]}, 32'hFF);
    check("t2_one_lo", {24'd0, mem[DST_BASE+2]}, 32'h0F);
    check("t2_one_hi", {24'd0, mem[DST_BASE+3]}, 32'h00);

    // 3: random messages with junk in the upper high-byte bits
    for (int i = 0; i < NUM_MSG; i++) begin msg[i] = 11'($urandom); junk[i] = 5'h1F ^ 5'(i); end
    load_mem();
    run("t3", 0, 0, cyc);
    for (int i = 0; i < 2*NUM_MSG; i++) img[i] = mem[DST_BASE + i];

    // 4: same image with pseudo-random grant
    load_mem();
    run("t4", 1, 0, cyc);
    diff = 0;
    for (int i = 0; i < 2*NUM_MSG; i++) if (mem[DST_BASE + i] !== img[i]) diff++;
    check("t4_image_diff", 32'(diff), 32'd0);

    // 5: reset in WR_LO of message 7, then a clean restart
    load_mem();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(mem_wr_en && mem_addr == 8'(DST_BASE + 14)) && cyc < 200) begin
      step();
      cyc++;
    end
    check("t5_reach_wrlo", 32'(cyc < 200), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_wr_gated", {31'd0, mem_wr_en}, 32'd0);
    step();
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    check("t5_idle_done", {31'd0, done}, 32'd0);
    check("t5_idle_addr", {24'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    step();
    check("t5_no_write", {24'd0, mem[DST_BASE + 14]}, 32'hA5);
    load_mem();
    run("t5r", 0, 0, cyc);
    check("t5r_latency", 32'(cyc), 32'd61);

    // 6: start pulsed while busy is ignored; start in DONE begins a second run
    load_mem();
    run("t6a", 0, 10, cyc);
    check("t6a_latency", 32'(cyc), 32'd61);
    repeat (3) step();
    check("t6_done_held", {31'd0, done}, 32'd1);
    load_mem();
    run("t6b", 0, 0, cyc);
    check("t6b_latency", 32'(cyc), 32'd61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
